// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : serialises fetch/data requests onto one stallmem-style memory
// Build option : ARB_RR_EN (round-robin tie-break instead of fixed D-over-I)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_stall,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_stall,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 1 = data port, 0 = instruction port
    logic          wr_q, wr_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   i_rdata_q, i_rdata_d;
    logic [15:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          w_gnt_dport;
    logic          w_gnt_iport;

`ifdef ARB_RR_EN
    logic last_q;                         // 1 = data port was granted last

    // On a tie, favour whichever port did not win the previous grant.
    assign w_gnt_dport = d_req & (~i_req | ~last_q);
    assign w_gnt_iport = i_req & ~w_gnt_dport;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else if (state_q == S_IDLE && (w_gnt_dport || w_gnt_iport)) begin
            last_q <= w_gnt_dport;
        end
    end
`else
    assign w_gnt_dport = d_req;
    assign w_gnt_iport = i_req & ~d_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_gnt_dport) begin
                    owner_d = 1'b1;
                    wr_d    = d_wr;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = S_ISSUE;
                end else if (w_gnt_iport) begin
                    owner_d = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = i_addr;
                    wdata_d = 16'h0000;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_stall) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    if (!owner_q) begin
                        i_rdata_d = mem_rdata;
                    end else if (!wr_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else if (cnt_q == c_CNT_LAST) begin
                    // Watchdog abort: complete the requester with zero data.
                    err_d = 1'b1;
                    if (owner_q) begin
                        d_rdata_d = 16'h0000;
                    end else begin
                        i_rdata_d = 16'h0000;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            cnt_q     <= '0;
            i_rdata_q <= 16'h0000;
            d_rdata_q <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign mem_addr  = (state_q == S_ISSUE) ? addr_q  : 16'h0000;
    assign mem_wdata = (state_q == S_ISSUE) ? wdata_q : 16'h0000;
    assign mem_rd    = (state_q == S_ISSUE) & ~wr_q;
    assign mem_wr    = (state_q == S_ISSUE) &  wr_q;

    assign i_done  = (state_q == S_RESP) & ~owner_q;
    assign d_done  = (state_q == S_RESP) &  owner_q;
    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a stallmem model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int TIMEOUT = 8;
    localparam int CW      = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_stall, i_done, d_stall, d_done;
    logic [15:0] i_rdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_done, mem_stall;
    logic        err;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_stall(i_stall), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall), .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_d;
        logic [15:0] data;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Memory model: k-cycle latency after acceptance, optional stall, optional no-Done.
    logic [15:0] mem [logic [15:0]];
    int   cfg_lat    = 3;
    int   cfg_stall  = 0;
    bit   cfg_never  = 0;
    int   stall_left = 0;
    bit   busy       = 0;
    int   wcnt       = 0;
    logic [15:0] rd_buf = 16'h0000;

    initial begin
        mem_stall = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (!rst) begin
                busy       = 0;
                mem_stall  = 1'b0;
                stall_left = cfg_stall;
            end else if (mem_rd || mem_wr) begin
                busy = 0;
                if (stall_left > 0) begin
                    mem_stall = 1'b1;
                    stall_left--;
                end else begin
                    mem_stall  = 1'b0;
                    busy       = 1;
                    wcnt       = 0;
                    stall_left = cfg_stall;
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    else rd_buf = mem.exists(mem_addr) ? mem[mem_addr] : 16'hDEAD;
                end
            end else begin
                mem_stall = 1'b0;
                if (busy) begin
                    wcnt++;
                    if (wcnt == cfg_lat && !cfg_never) begin
                        mem_done  = 1'b1;
                        mem_rdata = rd_buf;
                        busy      = 0;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_rd || mem_wr) check("mem_rd_wr_onehot", {mem_rd, mem_wr} == 2'b11, 0);
            if (i_done || d_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_done actual i_done=%0b d_done=%0b required none", i_done, d_done);
                end else begin
                    e = sbq.pop_front();
                    check("sb_port", {i_done, d_done}, e.is_d ? 2'b01 : 2'b10);
                    check("sb_rdata", e.is_d ? d_rdata : i_rdata, e.data);
                end
            end
        end
    end

    task automatic start_i(input logic [15:0] a, input bit push, input logic [15:0] exp);
        i_req  = 1'b1;
        i_addr = a;
        if (push) sbq.push_back({1'b0, exp});
    endtask

    task automatic start_d(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                           input bit push, input logic [15:0] exp);
        d_req   = 1'b1;
        d_wr    = wr;
        d_addr  = a;
        d_wdata = wd;
        if (push) sbq.push_back({1'b1, exp});
    endtask

    task automatic finish_i(input string nm, output int dcyc);
        int n = 0;
        do begin
            @(negedge clk);
            if (n == 0) check({nm, "_first"}, {i_stall, mem_rd | mem_wr}, 2'b10);
            n++;
        end while (!i_done && n < 200);
        dcyc = cyc;
        if (!i_done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual no i_done required i_done", nm);
        end else begin
            check({nm, "_stall_at_done"}, i_stall, 0);
        end
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic finish_d(input string nm, output int dcyc);
        int n = 0;
        do begin
            @(negedge clk);
            if (n == 0) check({nm, "_first"}, {d_stall, mem_rd | mem_wr}, 2'b10);
            n++;
        end while (!d_done && n < 200);
        dcyc = cyc;
        if (!d_done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual no d_done required d_done", nm);
        end else begin
            check({nm, "_stall_at_done"}, d_stall, 0);
        end
        @(posedge clk);
        #1 d_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1);
    end

    initial begin
        int c0, dc, dc2;
        mem[16'h0040] = 16'hBEEF;
        mem[16'h0044] = 16'hCAFE;
        mem[16'h0048] = 16'h1111;
        mem[16'h0200] = 16'h5A5A;
        mem[16'h0300] = 16'hA5A5;
        rst = 1'b0; i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;

        // Reset held with a pending fetch: nothing may reach the memory.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("reset_outputs", {i_done, d_done, d_stall, mem_rd, mem_wr, err,
                                    i_rdata, d_rdata, mem_addr, mem_wdata}, 80'd0);
            check("reset_i_stall", i_stall, 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        sbq.push_back({1'b0, 16'hBEEF});
        @(negedge clk);
        check("release_cycle1_rd", mem_rd, 0);
        @(negedge clk);
        check("release_cycle2_issue", {mem_rd, mem_addr}, {1'b1, 16'h0040});
        finish_i("rst_fetch", dc);

        // Single fetch, latency 3 after acceptance.
        c0 = cyc;
        start_i(16'h0040, 1, 16'hBEEF);
        finish_i("single_fetch", dc);
        check("single_fetch_latency", dc - c0, 5);

        // Memory stall for 4 cycles during ISSUE.
        cfg_stall = 4; stall_left = 4;
        c0 = cyc;
        start_i(16'h0048, 1, 16'h1111);
        fork
            finish_i("stall_fetch", dc);
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_rd_held", {mem_rd, mem_addr}, {1'b1, 16'h0048});
                end
                @(negedge clk);
                check("stall_wait_entered", mem_rd, 0);
            end
        join
        check("stall_fetch_latency", dc - c0, 9);
        cfg_stall = 0; stall_left = 0;

        // Contention: write wins, fetch follows.
        start_d(1'b1, 16'h0100, 16'h1234, 1, 16'h0000);
        start_i(16'h0044, 1, 16'hCAFE);
        fork
            finish_d("contend_wr", dc);
            finish_i("contend_fetch", dc2);
            begin
                @(negedge clk);
                @(negedge clk);
                check("contend_issue_wr", {mem_wr, mem_rd, mem_addr, mem_wdata},
                      {1'b1, 1'b0, 16'h0100, 16'h1234});
                check("contend_i_stalled", i_stall, 1);
            end
        join

        // Data burst against a pending fetch.
`ifdef ARB_RR_EN
        sbq.push_back({1'b1, 16'h1234});
        sbq.push_back({1'b0, 16'hBEEF});
        sbq.push_back({1'b1, 16'h5A5A});
`else
        sbq.push_back({1'b1, 16'h1234});
        sbq.push_back({1'b1, 16'h5A5A});
        sbq.push_back({1'b0, 16'hBEEF});
`endif
        start_d(1'b0, 16'h0100, 16'h0000, 0, 16'h0000);
        start_i(16'h0040, 0, 16'h0000);
        fork
            begin
                finish_d("burst_d1", dc);
                start_d(1'b0, 16'h0200, 16'h0000, 0, 16'h0000);
                finish_d("burst_d2", dc);
            end
            finish_i("burst_fetch", dc2);
        join

        // Watchdog: memory never answers.
        check("err_before_timeout", err, 0);
        cfg_never = 1;
        c0 = cyc;
        start_d(1'b0, 16'h0300, 16'h0000, 1, 16'h0000);
        finish_d("watchdog", dc);
        check("watchdog_latency", dc - c0, 10);
        check("watchdog_err_set", err, 1);
        cfg_never = 0;
        start_d(1'b0, 16'h0300, 16'h0000, 1, 16'hA5A5);
        finish_d("after_watchdog", dc);
        check("err_sticky", err, 1);

        // Back-to-back data requests; a write leaves d_rdata unchanged.
        start_d(1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF);
        finish_d("b2b_rd", dc);
        c0 = cyc;
        start_d(1'b1, 16'h0044, 16'h7777, 1, 16'hBEEF);
        finish_d("b2b_wr", dc);
        check("b2b_fresh_latency", dc - c0, 5);
        start_i(16'h0044, 1, 16'h7777);
        finish_i("b2b_fetch", dc);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
